// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU/mux selects and the bundled control-output struct.
package mips_ctrl_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEMADDR   = 4'd3;
    localparam logic [3:0] S_MEMREAD   = 4'd4;
    localparam logic [3:0] S_MEMWB     = 4'd5;
    localparam logic [3:0] S_MEMWRITE  = 4'd6;
    localparam logic [3:0] S_EXECUTE   = 4'd7;
    localparam logic [3:0] S_RCOMPLETE = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_ADDI_EXEC = 4'd11;
    localparam logic [3:0] S_ADDI_WB   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/control_out_decode.sv
// Combinational control-output decode: current state plus mem_ready (Mealy
// fetch writes) and opcode (illegal flag in DECODE) to the datapath controls.
module control_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ior_d     = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only capture in the cycle memory delivers the word.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_supported(opcode);
            end
            S_MEMADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RCOMPLETE: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: owns the state register and next-state logic,
// delegates per-state control outputs to control_out_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       illegal_op,
    output logic [3:0] state
);

    // Memory handshake: an access is in flight for as long as the FSM sits in
    // FETCH, MEMREAD or MEMWRITE; it completes on the rising edge where
    // mem_ready=1 is sampled in that state. No other state looks at mem_ready.

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       started_q;
    ctrl_t      ctrl;

    // IDLE is held for the first edge after reset release, so FETCH starts on
    // the second edge; afterwards IDLE always advances on the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = started_q ? S_FETCH : S_IDLE;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADDR: begin
                if (opcode == OP_LW)      state_d = S_MEMREAD;
                else if (opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD:   state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:     state_d = S_FETCH;
            S_MEMWRITE:  state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:   state_d = S_RCOMPLETE;
            S_RCOMPLETE: state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    control_out_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ior_d         = ctrl.ior_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_b     = ctrl.alu_src_b;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors for each
// instruction class, memory stalls, illegal opcode and async reset.
module tb_multicycle_control;

    typedef logic [20:0] vec_t;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BAD  = 6'b111111;

    // Vector layout: {pc_write, pc_write_cond, ior_d, mem_read, mem_write,
    // mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_op,
    // alu_src_b, illegal_op, state}
    localparam vec_t E_ZERO    = 21'd0;
    localparam vec_t E_FETCH_W = {10'b0001000000, 2'b00, 2'b00, 2'b01, 1'b0, 4'd1};
    localparam vec_t E_FETCH_R = {10'b1001001000, 2'b00, 2'b00, 2'b01, 1'b0, 4'd1};
    localparam vec_t E_DECODE  = {10'b0000000000, 2'b00, 2'b00, 2'b11, 1'b0, 4'd2};
    localparam vec_t E_ILLEGAL = {10'b0000000000, 2'b00, 2'b00, 2'b11, 1'b1, 4'd2};
    localparam vec_t E_MEMADDR = {10'b0000000100, 2'b00, 2'b00, 2'b10, 1'b0, 4'd3};
    localparam vec_t E_MEMREAD = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd4};
    localparam vec_t E_MEMWB   = {10'b0000010010, 2'b00, 2'b00, 2'b00, 1'b0, 4'd5};
    localparam vec_t E_MEMWR   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd6};
    localparam vec_t E_EXEC    = {10'b0000000100, 2'b00, 2'b10, 2'b00, 1'b0, 4'd7};
    localparam vec_t E_RCOMP   = {10'b0000000011, 2'b00, 2'b00, 2'b00, 1'b0, 4'd8};
    localparam vec_t E_BRANCH  = {10'b0100000100, 2'b01, 2'b01, 2'b00, 1'b0, 4'd9};
    localparam vec_t E_JUMP    = {10'b1000000000, 2'b10, 2'b00, 2'b00, 1'b0, 4'd10};
    localparam vec_t E_ADDIX   = {10'b0000000100, 2'b00, 2'b00, 2'b10, 1'b0, 4'd11};
    localparam vec_t E_ADDIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0, 4'd12};

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write;
    logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       illegal_op;
    logic [3:0] state;
    vec_t       obs;

    int total = 0;
    int bad   = 0;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ior_d         (ior_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .ir_write      (ir_write),
        .alu_src_a     (alu_src_a),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    assign obs = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg,
                  ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_op,
                  alu_src_b, illegal_op, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        opcode = T_R;
        mem_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++;
        if (obs !== E_ZERO) begin $display("FAIL reset_async: got %h want %h", obs, E_ZERO); bad++; end
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (obs !== E_ZERO) begin $display("FAIL reset_held: got %h want %h", obs, E_ZERO); bad++; end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== E_ZERO) begin $display("FAIL reset_rel_idle0: got %h want %h", obs, E_ZERO); bad++; end
        @(posedge clk); #1;
        total++;
        if (obs !== E_ZERO) begin $display("FAIL reset_rel_idle1: got %h want %h", obs, E_ZERO); bad++; end
        @(posedge clk); #1;
        total++;
        if (obs !== E_FETCH_W) begin $display("FAIL reset_first_fetch: got %h want %h", obs, E_FETCH_W); bad++; end
    endtask

    task automatic test_lw();
        logic [5:0] op [5] = '{T_R, T_LW, T_LW, T_LW, T_LW};
        logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec_t       ex [5] = '{E_FETCH_R, E_DECODE, E_MEMADDR, E_MEMREAD, E_MEMWB};
        for (int i = 0; i < 5; i++) begin
            opcode = op[i]; mem_ready = rdy[i]; #1;
            total++;
            if (obs !== ex[i]) begin $display("FAIL lw cyc%0d: got %h want %h", i, obs, ex[i]); bad++; end
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd1) begin $display("FAIL lw_end state: got %0d want 1", state); bad++; end
    endtask

    task automatic test_lw_wait();
        logic [5:0] op [8] = '{T_SW, T_LW, T_LW, T_R, T_BEQ, T_R, T_R, T_R};
        logic       rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vec_t       ex [8] = '{E_FETCH_R, E_DECODE, E_MEMADDR, E_MEMREAD, E_MEMREAD,
                               E_MEMREAD, E_MEMREAD, E_MEMWB};
        for (int i = 0; i < 8; i++) begin
            opcode = op[i]; mem_ready = rdy[i]; #1;
            total++;
            if (obs !== ex[i]) begin $display("FAIL lw_wait cyc%0d: got %h want %h", i, obs, ex[i]); bad++; end
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd1) begin $display("FAIL lw_wait_end state: got %0d want 1", state); bad++; end
    endtask

    task automatic test_back_to_back();
        logic [5:0] op [10] = '{T_LW, T_R, T_R, T_R, T_R, T_BEQ, T_BEQ, T_BEQ, T_J, T_J};
        logic       rdy [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vec_t       ex [10] = '{E_FETCH_R, E_DECODE, E_EXEC, E_RCOMP,
                                E_FETCH_R, E_DECODE, E_BRANCH,
                                E_FETCH_R, E_DECODE, E_JUMP};
        for (int i = 0; i < 10; i++) begin
            opcode = op[i]; mem_ready = rdy[i]; #1;
            total++;
            if (obs !== ex[i]) begin $display("FAIL b2b cyc%0d: got %h want %h", i, obs, ex[i]); bad++; end
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd1) begin $display("FAIL b2b_end state: got %0d want 1", state); bad++; end
    endtask

    task automatic test_fetch_stall();
        logic [5:0] op [6] = '{T_J, T_BEQ, T_R, T_ADDI, T_LW, T_SW};
        logic       rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec_t       ex [6] = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_ADDIX, E_ADDIWB};
        for (int i = 0; i < 6; i++) begin
            opcode = op[i]; mem_ready = rdy[i]; #1;
            total++;
            if (obs !== ex[i]) begin $display("FAIL fetch_stall cyc%0d: got %h want %h", i, obs, ex[i]); bad++; end
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd1) begin $display("FAIL fetch_stall_end state: got %0d want 1", state); bad++; end
    endtask

    task automatic test_sw();
        logic [5:0] op [5] = '{T_R, T_SW, T_SW, T_LW, T_LW};
        logic       rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vec_t       ex [5] = '{E_FETCH_R, E_DECODE, E_MEMADDR, E_MEMWR, E_MEMWR};
        for (int i = 0; i < 5; i++) begin
            opcode = op[i]; mem_ready = rdy[i]; #1;
            total++;
            if (obs !== ex[i]) begin $display("FAIL sw cyc%0d: got %h want %h", i, obs, ex[i]); bad++; end
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd1) begin $display("FAIL sw_end state: got %0d want 1", state); bad++; end
    endtask

    task automatic test_illegal();
        logic [5:0] op [3] = '{T_R, T_BAD, T_BAD};
        logic       rdy [3] = '{1'b1, 1'b1, 1'b0};
        vec_t       ex [3] = '{E_FETCH_R, E_ILLEGAL, E_FETCH_W};
        for (int i = 0; i < 3; i++) begin
            opcode = op[i]; mem_ready = rdy[i]; #1;
            total++;
            if (obs !== ex[i]) begin $display("FAIL illegal cyc%0d: got %h want %h", i, obs, ex[i]); bad++; end
            @(posedge clk); #1;
        end
        total++;
        if (state !== 4'd1) begin $display("FAIL illegal_end state: got %0d want 1", state); bad++; end
    endtask

    task automatic test_reset_mid();
        logic [5:0] op [4] = '{T_R, T_LW, T_LW, T_LW};
        logic       rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vec_t       ex [4] = '{E_FETCH_R, E_DECODE, E_MEMADDR, E_MEMREAD};
        for (int i = 0; i < 4; i++) begin
            opcode = op[i]; mem_ready = rdy[i]; #1;
            total++;
            if (obs !== ex[i]) begin $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs, ex[i]); bad++; end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (obs !== E_ZERO) begin $display("FAIL reset_mid_async: got %h want %h", obs, E_ZERO); bad++; end
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_ZERO) begin $display("FAIL reset_mid_idle0: got %h want %h", obs, E_ZERO); bad++; end
        @(posedge clk); #1;
        total++;
        if (obs !== E_ZERO) begin $display("FAIL reset_mid_idle1: got %h want %h", obs, E_ZERO); bad++; end
        @(posedge clk); #1;
        total++;
        if (obs !== E_FETCH_R) begin $display("FAIL reset_mid_fetch: got %h want %h", obs, E_FETCH_R); bad++; end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lw_wait();
        test_back_to_back();
        test_fetch_stall();
        test_sw();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
